hline_sequencer: RTL
====================

// Module: hline_sequencer
// PURPOSE
//  Game-level controller for the horizontal obstacle lines (h_line_* blocks).
//  Loads every line's motion counter, releases lines one at a time on a frame
//  schedule, and gates their motion. On a cube collision it freezes all lines
//  and drives the flash sequence, then parks in GAME OVER until restarted.
// PARAMETERS
//  NUM_LINES     8    number of h_line instances sequenced (1..15)
//  SPAWN_FRAMES  60   frame ticks between successive line releases (>=1)
//  FLASH_FRAMES  16   frame ticks per flash half-period (>=1)
//  FLASH_TOGGLES 8    flash toggles in FREEZE before GAME OVER (even, >=2)
// PORTS
//  clk            in   1          system clock; only clock in the block
//  reset          in   1          synchronous, active-high
//  frame_tick     in   1          1-cycle pulse per video frame
//  go             in   1          start/restart request (level; sampled)
//  collision      in   1          cube/line overlap; level, sampled on frame_tick
//  load_counter   out  1          drives LD of every line's motion counter
//  start_machine  out  NUM_LINES  bit i = line i released (its Lines_Motion start)
//  move_en        out  1          drives every line's 'stop' input; 1 = moving/solid
//  flash          out  1          drives every line's 'flash' input
//  active_count   out  4          number of lines released so far
//  game_over      out  1          high in OVER state
// BEHAVIOUR
//  Reset (any state, any cycle): state=IDLE, load_counter=0, start_machine=0,
//   move_en=0, flash=1 (frozen lines drawn solid), active_count=0,
//   game_over=0, frame timer cleared. All outputs registered.
//  States: IDLE, LOAD, RUN, FREEZE, OVER (encoded in package).
//  IDLE: go=1 -> LOAD next cycle.
//  LOAD: load_counter=1, start_machine=0, move_en=0. Held until two frame_tick
//   pulses seen (counters are frame-clocked; guarantees one full frame with LD
//   high). On 2nd tick -> RUN; same cycle start_machine[0]=1, active_count=1,
//   load_counter=0, move_en=1, timer cleared.
//  RUN: timer counts frame_ticks; when count reaches SPAWN_FRAMES-1 and a tick
//   arrives, set next start_machine bit (thermometer fill, bit index =
//   active_count), active_count++, timer cleared. When active_count==NUM_LINES
//   timer holds at 0, no further spawns, no wrap.
//   frame_tick with collision=1 -> FREEZE: move_en=0, flash=0, timer cleared,
//   toggle count cleared. Collision beats a coincident spawn (no spawn).
//   go and collision between ticks ignored.
//  FREEZE: start_machine held. Every FLASH_FRAMES ticks flash inverts and
//   toggle count++. After FLASH_TOGGLES toggles (flash back to 0 then forced 1)
//   -> OVER. collision/go ignored.
//  OVER: game_over=1, flash=1, move_en=0, start_machine held. go=1 -> LOAD
//   (game_over=0, start_machine=0, active_count=0 on entry).
//  Widths: timer width = $clog2(max(SPAWN_FRAMES,FLASH_FRAMES)+1); toggle count
//   $clog2(FLASH_TOGGLES+1); compares unsigned; active_count saturates.
//  go held continuously from OVER re-enters LOAD exactly once per OVER visit.
// STRUCTURE
//  Package hline_seq_pkg: state enum/localparams, default SPAWN/FLASH values.
//  One sub-module: frame_timer (tick-driven counter; inputs clr, en, tick,
//   terminal value; output done pulse). Instanced once, shared by RUN/FREEZE.
//  FSM, start_machine shift-fill and flash toggle live in the top.
// TESTING
//  1 reset mid-RUN (3 lines live) -> next cycle all outputs at reset values.
//  2 go in IDLE, NUM_LINES=4, SPAWN_FRAMES=3 -> load_counter high for 2 ticks,
//    start_machine 0001,0011,0111,1111 at ticks 2,5,8,11; stays 1111, count=4.
//  3 collision on same tick as a spawn -> FREEZE, start_machine unchanged,
//    move_en=0, flash=0.
//  4 FREEZE, FLASH_FRAMES=2, FLASH_TOGGLES=4 -> flash toggles every 2 ticks,
//    OVER after 8 ticks with flash=1, game_over=1.
//  5 collision pulse between ticks in RUN -> ignored, no FREEZE.
//  6 go held high through OVER -> single LOAD entry, counters and mask cleared.

Source files
------------

// File: rtl/hline_seq_pkg.sv
// Shared state encoding, default timing values and a small helper for the
// horizontal-line sequencer.
package hline_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_FREEZE = 3'd3,
    S_OVER   = 3'd4
  } state_e;

  localparam int DEF_NUM_LINES     = 8;
  localparam int DEF_SPAWN_FRAMES  = 60;
  localparam int DEF_FLASH_FRAMES  = 16;
  localparam int DEF_FLASH_TOGGLES = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick counter: counts ticks while enabled and pulses done on the tick
// that finds it at the terminal value, wrapping back to zero.
module frame_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         tick,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done = en && tick && !clr && (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick) begin
      cnt_d = (cnt_q == term) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hline_sequencer.sv
// Game-level controller for the horizontal obstacle lines: loads counters,
// releases lines on a frame schedule, freezes and flashes on collision.
module hline_sequencer
  import hline_seq_pkg::*;
#(
  parameter int NUM_LINES     = DEF_NUM_LINES,
  parameter int SPAWN_FRAMES  = DEF_SPAWN_FRAMES,
  parameter int FLASH_FRAMES  = DEF_FLASH_FRAMES,
  parameter int FLASH_TOGGLES = DEF_FLASH_TOGGLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 go,
  input  logic                 collision,
  output logic                 load_counter,
  output logic [NUM_LINES-1:0] start_machine,
  output logic                 move_en,
  output logic                 flash,
  output logic [3:0]           active_count,
  output logic                 game_over
);

  localparam int TW  = $clog2(max_int(SPAWN_FRAMES, FLASH_FRAMES) + 1);
  localparam int TGW = $clog2(FLASH_TOGGLES + 1);

  state_e               state_q, state_d;
  logic                 lc_q, lc_d;
  logic [NUM_LINES-1:0] sm_q, sm_d;
  logic                 me_q, me_d;
  logic                 fl_q, fl_d;
  logic [3:0]           ac_q, ac_d;
  logic                 over_q, over_d;
  logic [TGW-1:0]       tog_q, tog_d;

  logic                 tmr_clr, tmr_en, tmr_done;
  logic [TW-1:0]        tmr_term;

  // One timer serves all phases: the two LD ticks in LOAD, spawn spacing in
  // RUN and flash half-periods in FREEZE. It idles cleared in IDLE/OVER.
  assign tmr_en   = (state_q == S_LOAD) || (state_q == S_FREEZE) ||
                    ((state_q == S_RUN) && (ac_q < 4'(NUM_LINES)));
  assign tmr_clr  = (state_q == S_IDLE) || (state_q == S_OVER) ||
                    ((state_q == S_RUN) && frame_tick && collision);
  assign tmr_term = (state_q == S_LOAD)   ? TW'(1) :
                    (state_q == S_FREEZE) ? TW'(FLASH_FRAMES - 1) :
                                            TW'(SPAWN_FRAMES - 1);

  frame_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tick  (frame_tick),
    .term  (tmr_term),
    .done  (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    sm_d    = sm_q;
    me_d    = me_q;
    fl_d    = fl_q;
    ac_d    = ac_q;
    over_d  = over_q;
    tog_d   = tog_q;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (go) begin
          state_d = S_LOAD;
          lc_d    = 1'b1;
          sm_d    = '0;
          ac_d    = '0;
          over_d  = 1'b0;
          me_d    = 1'b0;
          fl_d    = 1'b1;
        end
      end
      S_LOAD: begin
        if (tmr_done) begin
          state_d = S_RUN;
          lc_d    = 1'b0;
          me_d    = 1'b1;
          sm_d    = NUM_LINES'(1);
          ac_d    = 4'd1;
        end
      end
      S_RUN: begin
        // A frozen frame takes precedence over a spawn due on the same tick.
        if (frame_tick && collision) begin
          state_d = S_FREEZE;
          me_d    = 1'b0;
          fl_d    = 1'b0;
          tog_d   = '0;
        end else if (tmr_done) begin
          sm_d = (sm_q << 1) | NUM_LINES'(1);
          ac_d = ac_q + 4'd1;
        end
      end
      S_FREEZE: begin
        if (tmr_done) begin
          if (tog_q == TGW'(FLASH_TOGGLES - 1)) begin
            state_d = S_OVER;
            fl_d    = 1'b1;
            over_d  = 1'b1;
          end else begin
            fl_d  = ~fl_q;
            tog_d = tog_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lc_q    <= 1'b0;
      sm_q    <= '0;
      me_q    <= 1'b0;
      fl_q    <= 1'b1;
      ac_q    <= '0;
      over_q  <= 1'b0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      sm_q    <= sm_d;
      me_q    <= me_d;
      fl_q    <= fl_d;
      ac_q    <= ac_d;
      over_q  <= over_d;
      tog_q   <= tog_d;
    end
  end

  assign load_counter  = lc_q;
  assign start_machine = sm_q;
  assign move_en       = me_q;
  assign flash         = fl_q;
  assign active_count  = ac_q;
  assign game_over     = over_q;

endmodule
